// File: rtl/reflet_timer.sv
// Memory-mapped countdown timer with a prescaler, one-shot/auto-reload modes and a level interrupt.
// Read data is registered and forced to zero when unselected so responders can be OR-combined.
module reflet_timer #(
    parameter int unsigned         wordsize  = 16,
    parameter logic [wordsize-1:0] base_addr = 16'hFF00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [wordsize-1:0] addr,
    input  logic [wordsize-1:0] data_in,
    input  logic                write_en,
    output logic [wordsize-1:0] data_out,
    output logic                int_out
);

    localparam int unsigned         Bytes = wordsize / 8;
    localparam logic [wordsize-1:0] Step  = wordsize'(Bytes);
    localparam logic [wordsize-1:0] Span  = wordsize'(5 * Bytes);
    localparam logic [wordsize-1:0] One   = wordsize'(1);

    // ctrl bits: [0] run, [1] auto_reload, [2] int_en
    logic [2:0]          ctrl_q, ctrl_d;
    logic [wordsize-1:0] prescale_q, prescale_d;
    logic [wordsize-1:0] reload_q, reload_d;
    logic [wordsize-1:0] count_q, count_d;
    logic [wordsize-1:0] pcnt_q, pcnt_d;
    logic                expired_q, expired_d;

    logic [wordsize-1:0] offset, index, rdata;
    logic [2:0]          reg_idx;
    logic                sel, wr, tick, expire;

    always_comb begin
        offset  = addr - base_addr;
        index   = offset / Step;
        sel     = (addr >= base_addr) && (offset < Span) && (index * Step == offset);
        reg_idx = index[2:0];
        wr      = write_en && sel && enable;
    end

    always_comb begin
        tick   = enable && ctrl_q[0] && (pcnt_q == prescale_q);
        expire = tick && (count_q == '0);

        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        reload_d   = reload_q;
        count_d    = count_q;
        pcnt_d     = pcnt_q;
        expired_d  = expired_q;

        if (enable && ctrl_q[0]) begin
            pcnt_d = tick ? '0 : pcnt_q + One;
        end

        if (tick) begin
            if (count_q != '0) begin
                count_d = count_q - One;
            end else if (ctrl_q[1]) begin
                count_d = reload_q;
            end else begin
                ctrl_d[0] = 1'b0;
            end
        end

        // Bus writes are applied after the tick so a write overrides the tick's update.
        if (wr) begin
            case (reg_idx)
                3'd0: ctrl_d     = data_in[2:0];
                3'd1: prescale_d = data_in;
                3'd2: reload_d   = data_in;
                3'd3: begin
                    count_d = data_in;
                    pcnt_d  = '0;
                end
                3'd4: begin
                    if (data_in[0]) begin
                        expired_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // A new expiry beats a simultaneous clear.
        if (expire) begin
            expired_d = 1'b1;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (reg_idx)
                3'd0:    rdata = {{(wordsize - 3){1'b0}}, ctrl_q};
                3'd1:    rdata = prescale_q;
                3'd2:    rdata = reload_q;
                3'd3:    rdata = count_q;
                3'd4:    rdata = {{(wordsize - 1){1'b0}}, expired_q};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            reload_q   <= '0;
            count_q    <= '0;
            pcnt_q     <= '0;
            expired_q  <= 1'b0;
            data_out   <= '0;
            int_out    <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            reload_q   <= reload_d;
            count_q    <= count_d;
            pcnt_q     <= pcnt_d;
            expired_q  <= expired_d;
            data_out   <= rdata;
            if (enable) begin
                int_out <= expired_d & ctrl_d[2];
            end
        end
    end

endmodule

// File: tb/tb_reflet_timer.sv
// Bench for reflet_timer: a directed vector table, hand-written corner sequences and
// randomized bus traffic checked every cycle against a register-file reference model.
module tb_reflet_timer;

    localparam logic [15:0] Base = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset, enable, write_en;
    logic [15:0] addr, data_in, data_out;
    logic        int_out;

    reflet_timer #(
        .wordsize (16),
        .base_addr(Base)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .addr    (addr),
        .data_in (data_in),
        .write_en(write_en),
        .data_out(data_out),
        .int_out (int_out)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: registers by offset (0 ctrl, 1 prescale, 2 reload, 3 count, 4 status).
    logic [15:0] m_reg [5];
    logic [15:0] m_pcnt;
    logic [15:0] m_dout;
    logic        m_int;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] d;
        logic        we;
        logic        rst;
        logic [15:0] exp_dout;
        logic        exp_int;
    } vec_t;

    vec_t vecs [18];

    function automatic vec_t mk(input logic [15:0] a, input logic [15:0] d, input logic we,
                                input logic rst, input logic [15:0] ed);
        vec_t v;
        v.a        = a;
        v.d        = d;
        v.we       = we;
        v.rst      = rst;
        v.exp_dout = ed;
        v.exp_int  = 1'b0;
        return v;
    endfunction

    function automatic int decode(input logic [15:0] a);
        int off;
        off = int'(a) - int'(Base);
        if (off < 0 || off >= 10 || (off % 2) != 0) return -1;
        return off / 2;
    endfunction

    task automatic model_step(input logic [15:0] a, input logic [15:0] d, input logic we,
                              input logic en, input logic rst);
        int k;
        bit tick, expire;
        k = decode(a);
        if (!rst) begin
            for (int i = 0; i < 5; i++) m_reg[i] = 16'h0;
            m_pcnt = 16'h0;
            m_dout = 16'h0;
            m_int  = 1'b0;
            return;
        end
        m_dout = (k >= 0) ? m_reg[k] : 16'h0;
        if (!en) return;
        tick   = m_reg[0][0] && (m_pcnt == m_reg[1]);
        expire = tick && (m_reg[3] == 16'h0);
        if (m_reg[0][0]) m_pcnt = tick ? 16'h0 : m_pcnt + 16'd1;
        if (tick) begin
            if (m_reg[3] != 16'h0) m_reg[3] = m_reg[3] - 16'd1;
            else if (m_reg[0][1]) m_reg[3] = m_reg[2];
            else m_reg[0][0] = 1'b0;
        end
        if (we && k >= 0) begin
            case (k)
                0: m_reg[0] = d & 16'h0007;
                3: begin
                    m_reg[3] = d;
                    m_pcnt   = 16'h0;
                end
                4: if (d[0]) m_reg[4] = 16'h0;
                default: m_reg[k] = d;
            endcase
        end
        if (expire) m_reg[4] = 16'h1;
        m_int = m_reg[4][0] && m_reg[0][2];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input logic [15:0] a, input logic [15:0] d, input logic we,
                        input logic en, input logic rst);
        addr     = a;
        data_in  = d;
        write_en = we;
        enable   = en;
        reset    = rst;
        model_step(a, d, we, en, rst);
        @(posedge clk);
        #1;
        check("model data_out", 32'(data_out), 32'(m_dout));
        check("model int_out", 32'(int_out), 32'(m_int));
    endtask

    task automatic wr(input int k, input logic [15:0] d);
        step(Base + 16'(2 * k), d, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic rd(input int k);
        step(Base + 16'(2 * k), 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic idle();
        step(16'h0000, 16'h0, 1'b0, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        step(16'h0000, 16'h0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset/idle reads and bus decode.
        vecs[0]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[1]  = mk(16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000);
        vecs[2]  = mk(16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[3]  = mk(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[4]  = mk(16'hFF04, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[5]  = mk(16'hFF06, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[6]  = mk(16'hFF08, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[7]  = mk(16'hFF01, 16'h1234, 1'b1, 1'b1, 16'h0000);
        vecs[8]  = mk(16'hFF0A, 16'h0055, 1'b1, 1'b1, 16'h0000);
        vecs[9]  = mk(16'hFF02, 16'h0007, 1'b1, 1'b1, 16'h0000);
        vecs[10] = mk(16'hFF01, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[11] = mk(16'hFF02, 16'h0000, 1'b0, 1'b1, 16'h0007);
        vecs[12] = mk(16'hFF0A, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[13] = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[14] = mk(16'hFF03, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[15] = mk(16'hFF08, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[16] = mk(16'hFF00, 16'h0000, 1'b0, 1'b1, 16'h0000);
        vecs[17] = mk(16'hFF06, 16'h0000, 1'b0, 1'b1, 16'h0000);

        for (int i = 0; i < 18; i++) begin
            step(vecs[i].a, vecs[i].d, vecs[i].we, 1'b1, vecs[i].rst);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp_dout));
            check($sformatf("vec%0d int_out", i), 32'(int_out), 32'(vecs[i].exp_int));
        end

        // One-shot: expiry and interrupt exactly 4 cycles after the CTRL write.
        do_reset();
        wr(1, 16'd0);
        wr(3, 16'd3);
        wr(0, 16'd5);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("oneshot int_out c%0d", i), 32'(int_out), 32'(i == 4));
        end
        rd(4);
        check("oneshot status", 32'(data_out), 32'd1);
        rd(0);
        check("oneshot ctrl", 32'(data_out), 32'd4);
        rd(3);
        check("oneshot count", 32'(data_out), 32'd0);

        // Auto-reload with prescale 2, reload 4: 15-cycle period, int_en off.
        do_reset();
        wr(1, 16'd2);
        wr(2, 16'd4);
        wr(3, 16'd4);
        wr(0, 16'd3);
        for (int j = 1; j <= 16; j++) begin
            rd(4);
            check($sformatf("reload status j%0d", j), 32'(data_out), 32'(j == 16));
            check("reload int_out low", 32'(int_out), 32'd0);
        end
        wr(4, 16'd1);
        check("reload int after clear", 32'(int_out), 32'd0);
        for (int j = 18; j <= 31; j++) begin
            rd(4);
            check($sformatf("reload status j%0d", j), 32'(data_out), 32'(j == 31));
            check("reload int_out low", 32'(int_out), 32'd0);
        end
        wr(0, 16'd7);
        check("int_en raises int_out", 32'(int_out), 32'd1);
        wr(4, 16'd1);
        check("status clear drops int_out", 32'(int_out), 32'd0);

        // Clear on the expiry edge, then COUNT write on a tick edge.
        do_reset();
        wr(1, 16'd0);
        wr(3, 16'd2);
        wr(0, 16'd3);
        idle();
        idle();
        wr(4, 16'd1);
        rd(4);
        check("set beats clear", 32'(data_out), 32'd1);
        wr(3, 16'd10);
        rd(3);
        check("count write beats tick", 32'(data_out), 32'd10);

        // CTRL write on a one-shot expiry edge keeps the written run bit.
        do_reset();
        wr(1, 16'd0);
        wr(3, 16'd0);
        wr(0, 16'd1);
        wr(0, 16'd5);
        check("ctrl write on expiry int_out", 32'(int_out), 32'd1);
        rd(0);
        check("ctrl write beats one-shot", 32'(data_out), 32'd5);
        rd(4);
        check("expired set with ctrl write", 32'(data_out), 32'd1);

        // Enable low freezes counting and blocks writes; reads still update.
        do_reset();
        wr(1, 16'd0);
        wr(3, 16'd20);
        wr(0, 16'd1);
        idle();
        idle();
        idle();
        for (int i = 0; i < 7; i++) begin
            step(Base + 16'd6, 16'd99, 1'b1, 1'b0, 1'b1);
            check($sformatf("frozen count c%0d", i), 32'(data_out), 32'd17);
        end
        rd(3);
        check("count after enable", 32'(data_out), 32'd17);
        do_reset();
        check("reset data_out", 32'(data_out), 32'd0);
        check("reset int_out", 32'(int_out), 32'd0);
        for (int k = 0; k < 5; k++) begin
            rd(k);
            check($sformatf("post-reset reg%0d", k), 32'(data_out), 32'd0);
        end

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            int r;
            logic [15:0] a, d;
            r = $urandom_range(0, 12);
            if (r <= 10) a = Base + 16'(r);
            else a = 16'($urandom);
            d = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 6));
            step(a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 9) != 0,
                 $urandom_range(0, 299) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
